bsg_manycore_cache_op_sequencer: RTL

BSG_MANYCORE_CACHE_OP_SEQUENCER -- requirements
Module: bsg_manycore_cache_op_sequencer

---
 rtl/bsg_manycore_cache_op_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bsg_manycore_cache_op_sequencer.sv
// Issues a burst of cache-op requests (one per cache line) to a remote cache,
// metering them against returned credits and reporting done/error.
module bsg_manycore_cache_op_sequencer #(
  parameter int addr_width_p      = 28,
  parameter int x_cord_width_p    = 7,
  parameter int y_cord_width_p    = 7,
  parameter int count_width_p     = 16,
  parameter int stride_p          = 8,
  parameter int max_out_credits_p = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      cmd_v_i,
  input  logic [4:0]                cmd_subop_i,
  input  logic [addr_width_p-1:0]   cmd_addr_i,
  input  logic [count_width_p-1:0]  cmd_count_i,
  input  logic [x_cord_width_p-1:0] cmd_x_i,
  input  logic [y_cord_width_p-1:0] cmd_y_i,
  output logic                      cmd_ready_o,

  output logic                      out_v_o,
  output logic [3:0]                out_op_o,
  output logic [4:0]                out_reg_id_o,
  output logic [addr_width_p-1:0]   out_addr_o,
  output logic [x_cord_width_p-1:0] out_x_o,
  output logic [y_cord_width_p-1:0] out_y_o,
  input  logic                      out_ready_i,

  input  logic                      returned_v_i,
  input  logic [1:0]                returned_type_i,

  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o
);

  localparam int out_width_lp = $clog2(max_out_credits_p + 1);
  localparam logic [out_width_lp-1:0] max_credits_lp = out_width_lp'(max_out_credits_p);
  localparam logic [3:0] e_cache_op = 4'd3;

  localparam logic [1:0] idle_s  = 2'd0;
  localparam logic [1:0] issue_s = 2'd1;
  localparam logic [1:0] drain_s = 2'd2;
  localparam logic [1:0] done_s  = 2'd3;

  logic [1:0]                state_r;
  logic [4:0]                subop_r;
  logic [addr_width_p-1:0]   addr_r;
  logic [count_width_p-1:0]  remaining_r;
  logic [out_width_lp-1:0]   outstanding_r;
  logic [x_cord_width_p-1:0] x_r;
  logic [y_cord_width_p-1:0] y_r;
  logic                      error_r;

  logic cmd_accept, handshake, credit_ok, bad_return, bad_subop;

  assign cmd_ready_o = (state_r == idle_s);
  assign cmd_accept  = cmd_v_i & cmd_ready_o;
  assign bad_subop   = (cmd_subop_i > 5'd3);

  // A credit only counts if something is actually outstanding; anything else is a protocol error.
  assign credit_ok  = returned_v_i & (returned_type_i == 2'd0) & (outstanding_r != '0);
  assign bad_return = returned_v_i & ~credit_ok;

  // Valid depends only on registered state, so it cannot drop while waiting for ready.
  assign out_v_o = (state_r == issue_s) && (remaining_r != '0)
                && (outstanding_r < max_credits_lp);
  assign handshake = out_v_o & out_ready_i;

  assign out_op_o     = e_cache_op;
  assign out_reg_id_o = subop_r;
  assign out_addr_o   = addr_r;
  assign out_x_o      = x_r;
  assign out_y_o      = y_r;

  assign busy_o  = (state_r != idle_s);
  assign done_o  = (state_r == done_s);
  assign error_o = error_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      outstanding_r <= '0;
    end else if (handshake & ~credit_ok) begin
      outstanding_r <= outstanding_r + 1'b1;
    end else if (~handshake & credit_ok) begin
      outstanding_r <= outstanding_r - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if (cmd_accept) begin
      error_r <= bad_subop | bad_return;
    end else if (bad_return) begin
      error_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= idle_s;
      subop_r     <= '0;
      addr_r      <= '0;
      remaining_r <= '0;
      x_r         <= '0;
      y_r         <= '0;
    end else begin
      case (state_r)
        idle_s: begin
          if (cmd_accept) begin
            subop_r     <= cmd_subop_i;
            addr_r      <= cmd_addr_i;
            remaining_r <= cmd_count_i;
            x_r         <= cmd_x_i;
            y_r         <= cmd_y_i;
            state_r     <= ((cmd_count_i != '0) && !bad_subop) ? issue_s : done_s;
          end
        end
        issue_s: begin
          if (handshake) begin
            addr_r      <= addr_r + addr_width_p'(stride_p);
            remaining_r <= remaining_r - count_width_p'(1);
            if (remaining_r == count_width_p'(1)) state_r <= drain_s;
          end
        end
        drain_s: begin
          if (outstanding_r == '0) state_r <= done_s;
        end
        default: state_r <= idle_s;
      endcase
    end
  end

endmodule
